mem_port_arbiter: RTL and testbench

//  Shares one external memory port among NUM_CHANNELS d_cache instances, e.g. the duplicated

---
 rtl/mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one external memory port among NUM_CHANNELS cache
//               instances. One channel is granted per burst using a
//               round-robin policy. The granted channel's request is forwarded
//               to memory, and memory beats are steered back to that channel
//               only. Channels that are not granted see an all-zero bus.
//
// Parameters  : NUM_CHANNELS    number of requesting caches (>= 2)
//               DATA_WIDTH      memory data word width
//               MEM_ADDR_WIDTH  memory address width
//
// Ports       : i_Clk, i_Reset_n          clock, async active-low reset
//               i_Req_*  (per channel)    cache request side (valid, dir,
//                                         address, write data), packed with
//                                         channel c at [c*W +: W]
//               o_Rsp_*  (per channel)    memory beats steered to the caches
//               o_MEM_*                   request to the memory model
//               i_MEM_*                   beats from the memory model
//               o_Grant                   one-hot grant, 0 while idle
//               o_Busy                    arbiter is not idle
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_CHANNELS   = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 22
) (
    input  logic                                   i_Clk,
    input  logic                                   i_Reset_n,

    // Cache-facing request side
    input  logic [NUM_CHANNELS-1:0]                i_Req_Valid,
    input  logic [NUM_CHANNELS-1:0]                i_Req_Read_Write_n,
    input  logic [NUM_CHANNELS*MEM_ADDR_WIDTH-1:0] i_Req_Address,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]     i_Req_Data,

    // Cache-facing response side
    output logic [NUM_CHANNELS-1:0]                o_Rsp_Valid,
    output logic [NUM_CHANNELS-1:0]                o_Rsp_Data_Read,
    output logic [NUM_CHANNELS-1:0]                o_Rsp_Last,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]     o_Rsp_Data,

    // Memory-facing request side
    output logic                                   o_MEM_Valid,
    output logic                                   o_MEM_Read_Write_n,
    output logic [MEM_ADDR_WIDTH-1:0]              o_MEM_Address,
    output logic [DATA_WIDTH-1:0]                  o_MEM_Data,

    // Memory-facing response side
    input  logic                                   i_MEM_Valid,
    input  logic                                   i_MEM_Data_Read,
    input  logic                                   i_MEM_Last,
    input  logic [DATA_WIDTH-1:0]                  i_MEM_Data,

    // Status
    output logic [NUM_CHANNELS-1:0]                o_Grant,
    output logic                                   o_Busy
);

    // Grant index width; never narrower than one bit.
    localparam int CH_IDX_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,   // waiting for any request
        S_BUSY    = 2'd1,   // forwarding the granted channel
        S_RELEASE = 2'd2    // burst done, waiting for the cache to drop valid
    } state_t;

    // Adds an offset to a channel index, wrapping modulo NUM_CHANNELS.
    // Offsets used here never exceed NUM_CHANNELS-1, so a single subtract
    // is enough to wrap.
    function automatic logic [CH_IDX_WIDTH-1:0] f_wrap_add(
        input logic [CH_IDX_WIDTH-1:0] base,
        input int                      offset
    );
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CHANNELS) begin
            sum = sum - NUM_CHANNELS;
        end
        return CH_IDX_WIDTH'(sum);
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                    r_state;
    logic [CH_IDX_WIDTH-1:0]   r_grant_idx;
    logic [CH_IDX_WIDTH-1:0]   r_rr_ptr;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t                    w_next_state;
    logic [CH_IDX_WIDTH-1:0]   w_next_grant_idx;
    logic [CH_IDX_WIDTH-1:0]   w_next_rr_ptr;

    logic [CH_IDX_WIDTH-1:0]   w_scan_idx [NUM_CHANNELS];
    logic [CH_IDX_WIDTH-1:0]   w_pick_idx;
    logic                      w_pick_found;

    logic [MEM_ADDR_WIDTH-1:0] w_req_addr [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]     w_req_data [NUM_CHANNELS];

    logic                      w_active;
    logic                      w_grant_req_valid;
    logic                      w_beat_last;
    logic [CH_IDX_WIDTH-1:0]   w_grant_next_ptr;
    logic                      w_mem_valid;
    logic [NUM_CHANNELS-1:0]   w_sel;

    // ------------------------------------------------------------------------
    // Per-channel unpacking, scan order and response steering
    // ------------------------------------------------------------------------
    generate
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
            localparam logic [CH_IDX_WIDTH-1:0] c_ch_idx = CH_IDX_WIDTH'(c);

            assign w_req_addr[c] = i_Req_Address[c*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
            assign w_req_data[c] = i_Req_Data[c*DATA_WIDTH +: DATA_WIDTH];

            // Position c of the round-robin scan: rr_ptr + c, wrapped.
            assign w_scan_idx[c] = f_wrap_add(r_rr_ptr, c);

            // Responses stay steered in RELEASE so a trailing beat still
            // reaches the owner; in IDLE every channel sees zeros.
            assign w_sel[c]           = w_active & (r_grant_idx == c_ch_idx);
            assign o_Grant[c]         = w_sel[c];
            assign o_Rsp_Valid[c]     = w_sel[c] & i_MEM_Valid;
            assign o_Rsp_Data_Read[c] = w_sel[c] & i_MEM_Data_Read;
            assign o_Rsp_Last[c]      = w_sel[c] & i_MEM_Last;
            assign o_Rsp_Data[c*DATA_WIDTH +: DATA_WIDTH] =
                w_sel[c] ? i_MEM_Data : '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin pick: first requesting channel at or after rr_ptr.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pick_idx   = r_rr_ptr;
        w_pick_found = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!w_pick_found && i_Req_Valid[w_scan_idx[i]]) begin
                w_pick_idx   = w_scan_idx[i];
                w_pick_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shared status terms
    // ------------------------------------------------------------------------
    assign w_active          = (r_state != S_IDLE);
    assign w_grant_req_valid = i_Req_Valid[r_grant_idx];
    // A burst ends on the last beat in either direction.
    assign w_beat_last       = i_MEM_Last & (i_MEM_Valid | i_MEM_Data_Read);
    // The channel after the current owner gets first look next time.
    assign w_grant_next_ptr  = f_wrap_add(r_grant_idx, 1);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state     <= S_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_next_state;
            r_grant_idx <= w_next_grant_idx;
            r_rr_ptr    <= w_next_rr_ptr;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state     = r_state;
        w_next_grant_idx = r_grant_idx;
        w_next_rr_ptr    = r_rr_ptr;

        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_next_grant_idx = w_pick_idx;
                    w_next_state     = S_BUSY;
                end
            end

            S_BUSY: begin
                if (w_beat_last) begin
                    w_next_state = S_RELEASE;
                end else if (!w_grant_req_valid) begin
                    // Owner withdrew its request before the burst ended.
                    w_next_state  = S_IDLE;
                    w_next_rr_ptr = w_grant_next_ptr;
                end
            end

            S_RELEASE: begin
                // Hold the grant until the cache has retired its request, so
                // a still-asserted valid is not mistaken for a new one.
                if (!w_grant_req_valid) begin
                    w_next_state  = S_IDLE;
                    w_next_rr_ptr = w_grant_next_ptr;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request forwarding; every field is zero whenever valid is low.
    // ------------------------------------------------------------------------
    assign w_mem_valid        = (r_state == S_BUSY) & w_grant_req_valid;
    assign o_MEM_Valid        = w_mem_valid;
    assign o_MEM_Read_Write_n = w_mem_valid & i_Req_Read_Write_n[r_grant_idx];
    assign o_MEM_Address      = w_mem_valid ? w_req_addr[r_grant_idx] : '0;
    assign o_MEM_Data         = w_mem_valid ? w_req_data[r_grant_idx] : '0;

    assign o_Busy = w_active;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A two-channel
//               instance is driven from a table of per-cycle vectors plus a
//               hand-written mid-burst reset sequence; a four-channel instance
//               checks round-robin rotation with every channel requesting.
//               Expected values are queued when stimulus is applied and popped
//               when the outputs are sampled on the falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Two-channel instance
    // ------------------------------------------------------------------------
    logic [1:0]  req_valid2, req_rw2;
    logic [43:0] req_addr2;
    logic [63:0] req_data2;
    logic        mem_valid2, mem_dr2, mem_last2;
    logic [31:0] mem_data2;
    logic [1:0]  rsp_valid2, rsp_dr2, rsp_last2, grant2;
    logic [63:0] rsp_data2;
    logic        mem_v_o2, mem_rw_o2, busy2;
    logic [21:0] mem_addr_o2;
    logic [31:0] mem_wdata_o2;

    mem_port_arbiter #(
        .NUM_CHANNELS  (2),
        .DATA_WIDTH    (32),
        .MEM_ADDR_WIDTH(22)
    ) dut2 (
        .i_Clk             (clk),
        .i_Reset_n         (rst_n),
        .i_Req_Valid       (req_valid2),
        .i_Req_Read_Write_n(req_rw2),
        .i_Req_Address     (req_addr2),
        .i_Req_Data        (req_data2),
        .o_Rsp_Valid       (rsp_valid2),
        .o_Rsp_Data_Read   (rsp_dr2),
        .o_Rsp_Last        (rsp_last2),
        .o_Rsp_Data        (rsp_data2),
        .o_MEM_Valid       (mem_v_o2),
        .o_MEM_Read_Write_n(mem_rw_o2),
        .o_MEM_Address     (mem_addr_o2),
        .o_MEM_Data        (mem_wdata_o2),
        .i_MEM_Valid       (mem_valid2),
        .i_MEM_Data_Read   (mem_dr2),
        .i_MEM_Last        (mem_last2),
        .i_MEM_Data        (mem_data2),
        .o_Grant           (grant2),
        .o_Busy            (busy2)
    );

    // ------------------------------------------------------------------------
    // Four-channel instance
    // ------------------------------------------------------------------------
    logic [3:0]   req_valid4, req_rw4;
    logic [87:0]  req_addr4;
    logic [127:0] req_data4;
    logic         mem_valid4, mem_dr4, mem_last4;
    logic [31:0]  mem_data4;
    logic [3:0]   rsp_valid4, rsp_dr4, rsp_last4, grant4;
    logic [127:0] rsp_data4;
    logic         mem_v_o4, mem_rw_o4, busy4;
    logic [21:0]  mem_addr_o4;
    logic [31:0]  mem_wdata_o4;

    mem_port_arbiter #(
        .NUM_CHANNELS  (4),
        .DATA_WIDTH    (32),
        .MEM_ADDR_WIDTH(22)
    ) dut4 (
        .i_Clk             (clk),
        .i_Reset_n         (rst_n),
        .i_Req_Valid       (req_valid4),
        .i_Req_Read_Write_n(req_rw4),
        .i_Req_Address     (req_addr4),
        .i_Req_Data        (req_data4),
        .o_Rsp_Valid       (rsp_valid4),
        .o_Rsp_Data_Read   (rsp_dr4),
        .o_Rsp_Last        (rsp_last4),
        .o_Rsp_Data        (rsp_data4),
        .o_MEM_Valid       (mem_v_o4),
        .o_MEM_Read_Write_n(mem_rw_o4),
        .o_MEM_Address     (mem_addr_o4),
        .o_MEM_Data        (mem_wdata_o4),
        .i_MEM_Valid       (mem_valid4),
        .i_MEM_Data_Read   (mem_dr4),
        .i_MEM_Last        (mem_last4),
        .i_MEM_Data        (mem_data4),
        .o_Grant           (grant4),
        .o_Busy            (busy4)
    );

    // ------------------------------------------------------------------------
    // Vector types
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]  valid;
        logic [1:0]  rw;
        logic [21:0] a1;
        logic [21:0] a0;
        logic [31:0] d1;
        logic [31:0] d0;
        logic        mv;
        logic        mdr;
        logic        ml;
        logic [31:0] md;
    } in2_t;

    typedef struct packed {
        logic [1:0]  grant;
        logic        busy;
        logic        mv;
        logic        rw;
        logic [21:0] addr;
        logic [31:0] wdata;
        logic [1:0]  rv;
        logic [1:0]  rdr;
        logic [1:0]  rl;
        logic [63:0] rdata;
    } out2_t;

    typedef struct {
        string name;
        in2_t  stim;
        out2_t exp;
    } vec_t;

    out2_t act2;
    assign act2 = {grant2, busy2, mem_v_o2, mem_rw_o2, mem_addr_o2, mem_wdata_o2,
                   rsp_valid2, rsp_dr2, rsp_last2, rsp_data2};

    vec_t        vecs[$];
    out2_t       sb2_q[$];
    logic [63:0] sb4_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic in2_t mk_in(logic [1:0] v, logic [1:0] rw,
                                   logic [21:0] a1, logic [21:0] a0,
                                   logic [31:0] d1, logic [31:0] d0,
                                   logic mv, logic mdr, logic ml, logic [31:0] md);
        in2_t s;
        s = '{v, rw, a1, a0, d1, d0, mv, mdr, ml, md};
        return s;
    endfunction

    function automatic out2_t mk_out(logic [1:0] g, logic busy, logic mv, logic rw,
                                     logic [21:0] addr, logic [31:0] wd,
                                     logic [1:0] rv, logic [1:0] rdr, logic [1:0] rl,
                                     logic [63:0] rdata);
        out2_t o;
        o = '{g, busy, mv, rw, addr, wd, rv, rdr, rl, rdata};
        return o;
    endfunction

    task automatic add(input string name, input in2_t s, input out2_t e);
        vec_t v;
        v.name = name;
        v.stim = s;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic apply2(input in2_t s);
        req_valid2 = s.valid;
        req_rw2    = s.rw;
        req_addr2  = {s.a1, s.a0};
        req_data2  = {s.d1, s.d0};
        mem_valid2 = s.mv;
        mem_dr2    = s.mdr;
        mem_last2  = s.ml;
        mem_data2  = s.md;
    endtask

    task automatic check2(input string name);
        out2_t e;
        e = sb2_q.pop_front();
        n_cmp++;
        if (act2 !== e) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act2, e);
        end
    endtask

    // One cycle: apply inputs, queue expectation, compare on falling edge.
    task automatic run_vec(input vec_t v);
        apply2(v.stim);
        sb2_q.push_back(v.exp);
        @(negedge clk);
        check2(v.name);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp4(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    localparam logic [21:0] c_a_rd   = 22'h00100;
    localparam logic [21:0] c_a_junk = 22'h2AAAA;
    localparam logic [21:0] c_a_wr   = 22'h3FFFFE;
    localparam logic [31:0] c_wd     = 32'hDEADBEEF;

    initial begin
        out2_t z;
        z = '0;

        // ---------------- vector table (two-channel instance) ----------------
        add("post_reset_idle", mk_in(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), z);
        // Single read on ch0; ch1 toggles its request fields while ch0 owns the port.
        add("rd_req",    mk_in(2'b01, 2'b01, 0, c_a_rd, 0, 0, 0, 0, 0, 0), z);
        add("rd_fwd",    mk_in(2'b01, 2'b01, 0, c_a_rd, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b01, 1, 1, 1, c_a_rd, 0, 2'b00, 2'b00, 2'b00, 0));
        add("rd_beat0",  mk_in(2'b11, 2'b01, c_a_junk, c_a_rd, 32'h1111, 0, 1, 0, 0, 32'hA0),
                         mk_out(2'b01, 1, 1, 1, c_a_rd, 0, 2'b01, 2'b00, 2'b00, 64'hA0));
        add("rd_beat1",  mk_in(2'b01, 2'b11, 22'h12345, c_a_rd, 0, 0, 1, 0, 0, 32'hA1),
                         mk_out(2'b01, 1, 1, 1, c_a_rd, 0, 2'b01, 2'b00, 2'b00, 64'hA1));
        add("rd_beat2",  mk_in(2'b11, 2'b01, 22'h00001, c_a_rd, 32'h2222, 0, 1, 0, 0, 32'hA2),
                         mk_out(2'b01, 1, 1, 1, c_a_rd, 0, 2'b01, 2'b00, 2'b00, 64'hA2));
        add("rd_last",   mk_in(2'b11, 2'b11, 22'h3F000, c_a_rd, 0, 0, 1, 0, 1, 32'hA3),
                         mk_out(2'b01, 1, 1, 1, c_a_rd, 0, 2'b01, 2'b00, 2'b01, 64'hA3));
        add("rd_rel_hold", mk_in(2'b01, 2'b01, 0, c_a_rd, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b01, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        add("rd_rel_drop", mk_in(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b01, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        add("idle_beat_dropped", mk_in(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 1, 32'h55), z);
        // Tie with rr_ptr=1: ch1 first, then ch0 after the pointer wraps to 0.
        add("tie_req",   mk_in(2'b11, 2'b11, 22'h00200, 22'h00300, 0, 0, 0, 0, 0, 0), z);
        add("tie_ch1_fwd", mk_in(2'b11, 2'b11, 22'h00200, 22'h00300, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b10, 1, 1, 1, 22'h00200, 0, 2'b00, 2'b00, 2'b00, 0));
        add("tie_ch1_last", mk_in(2'b11, 2'b11, 22'h00200, 22'h00300, 0, 0, 1, 0, 1, 32'hB0),
                         mk_out(2'b10, 1, 1, 1, 22'h00200, 0, 2'b10, 2'b00, 2'b10, {32'hB0, 32'h0}));
        add("tie_ch1_drop", mk_in(2'b01, 2'b11, 0, 22'h00300, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b10, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        add("tie_ch0_arb", mk_in(2'b01, 2'b11, 0, 22'h00300, 0, 0, 0, 0, 0, 0), z);
        add("tie_ch0_fwd", mk_in(2'b01, 2'b11, 0, 22'h00300, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b01, 1, 1, 1, 22'h00300, 0, 2'b00, 2'b00, 2'b00, 0));
        add("tie_ch0_last", mk_in(2'b01, 2'b11, 0, 22'h00300, 0, 0, 1, 0, 1, 32'hB1),
                         mk_out(2'b01, 1, 1, 1, 22'h00300, 0, 2'b01, 2'b00, 2'b01, 64'hB1));
        add("tie_ch0_drop", mk_in(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b01, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        // Write burst on ch1 at the top of the address range.
        add("wr_req",    mk_in(2'b10, 2'b00, c_a_wr, 0, c_wd, 0, 0, 0, 0, 0), z);
        add("wr_fwd",    mk_in(2'b10, 2'b00, c_a_wr, 0, c_wd, 0, 0, 0, 0, 0),
                         mk_out(2'b10, 1, 1, 0, c_a_wr, c_wd, 2'b00, 2'b00, 2'b00, 0));
        add("wr_beat",   mk_in(2'b10, 2'b00, c_a_wr, 0, c_wd, 0, 0, 1, 0, 0),
                         mk_out(2'b10, 1, 1, 0, c_a_wr, c_wd, 2'b00, 2'b10, 2'b00, 0));
        add("wr_last",   mk_in(2'b10, 2'b00, c_a_wr, 0, c_wd, 0, 0, 1, 1, 0),
                         mk_out(2'b10, 1, 1, 0, c_a_wr, c_wd, 2'b00, 2'b10, 2'b10, 0));
        add("wr_drop",   mk_in(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b10, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        // Abort: owner drops valid mid-burst, pointer still advances.
        add("ab_req",    mk_in(2'b01, 2'b01, 0, 22'h00400, 0, 0, 0, 0, 0, 0), z);
        add("ab_fwd",    mk_in(2'b01, 2'b01, 0, 22'h00400, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b01, 1, 1, 1, 22'h00400, 0, 2'b00, 2'b00, 2'b00, 0));
        add("ab_drop",   mk_in(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b01, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        add("ab_tie_req", mk_in(2'b11, 2'b11, 22'h00500, 22'h00600, 0, 0, 0, 0, 0, 0), z);
        add("ab_tie_ch1", mk_in(2'b11, 2'b11, 22'h00500, 22'h00600, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b10, 1, 1, 1, 22'h00500, 0, 2'b00, 2'b00, 2'b00, 0));
        add("ab_ch1_abort", mk_in(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
                         mk_out(2'b10, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));

        // ---------------- reset ----------------
        rst_n      = 1'b0;
        apply2('0);
        req_valid4 = '0;
        req_rw4    = '1;
        req_addr4  = {22'h103, 22'h102, 22'h101, 22'h100};
        req_data4  = '0;
        mem_valid4 = 1'b0;
        mem_dr4    = 1'b0;
        mem_last4  = 1'b0;
        mem_data4  = '0;
        repeat (2) @(posedge clk);
        #1;
        // Outputs stay silent under reset even with live inputs.
        apply2(mk_in(2'b01, 2'b01, 0, c_a_rd, 0, 0, 1, 1, 1, 32'h77));
        sb2_q.push_back(z);
        @(negedge clk);
        check2("reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // ---------------- mid-burst reset ----------------
        begin
            vec_t v;
            v.name = "mr_req";
            v.stim = mk_in(2'b01, 2'b01, 0, 22'h00700, 0, 0, 0, 0, 0, 0);
            v.exp  = z;
            run_vec(v);
            v.name = "mr_fwd";
            v.exp  = mk_out(2'b01, 1, 1, 1, 22'h00700, 0, 2'b00, 2'b00, 2'b00, 0);
            run_vec(v);
            v.name = "mr_beat0";
            v.stim = mk_in(2'b01, 2'b01, 0, 22'h00700, 0, 0, 1, 0, 0, 32'hC0);
            v.exp  = mk_out(2'b01, 1, 1, 1, 22'h00700, 0, 2'b01, 2'b00, 2'b00, 64'hC0);
            run_vec(v);
            v.name = "mr_beat1";
            v.stim = mk_in(2'b01, 2'b01, 0, 22'h00700, 0, 0, 1, 0, 0, 32'hC1);
            v.exp  = mk_out(2'b01, 1, 1, 1, 22'h00700, 0, 2'b01, 2'b00, 2'b00, 64'hC1);
            run_vec(v);

            apply2(mk_in(2'b01, 2'b01, 0, 22'h00700, 0, 0, 1, 0, 0, 32'hC2));
            rst_n = 1'b0;
            #1;
            sb2_q.push_back(z);
            check2("mr_async_zero");
            @(negedge clk);
            sb2_q.push_back(z);
            check2("mr_reset_cycle");
            @(posedge clk);
            #1;
            rst_n = 1'b1;

            v.name = "mr_tie_req";
            v.stim = mk_in(2'b11, 2'b11, 22'h00800, 22'h00900, 0, 0, 0, 0, 0, 0);
            v.exp  = z;
            run_vec(v);
            v.name = "mr_tie_ch0";
            v.exp  = mk_out(2'b01, 1, 1, 1, 22'h00900, 0, 2'b00, 2'b00, 2'b00, 0);
            run_vec(v);
            v.name = "mr_abort";
            v.stim = '0;
            v.exp  = mk_out(2'b01, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            run_vec(v);
        end

        // ---------------- four channels, all requesting ----------------
        req_valid4 = 4'hF;
        for (int b = 0; b < 5; b++) begin
            int          k;
            bit          seen;
            logic [63:0] e;
            logic [63:0] a;
            logic [127:0] ed;
            k    = b % 4;
            e    = '0;
            e[3:0]   = 4'(1 << k);
            e[4]     = 1'b1;
            e[5]     = 1'b1;
            e[27:6]  = 22'h100 + 22'(k);
            sb4_q.push_back(e);
            seen = 1'b0;
            for (int t = 0; t < 8 && !seen; t++) begin
                @(negedge clk);
                if (mem_v_o4) seen = 1'b1;
            end
            if (!seen) begin
                void'(sb4_q.pop_front());
                n_cmp++;
                n_err++;
                $display("FAIL n4_grant%0d: no request reached memory, want channel %0d", b, k);
                break;
            end
            a = {4'h0, mem_wdata_o4, mem_addr_o4, mem_rw_o4, busy4, grant4};
            cmp4($sformatf("n4_grant%0d", b), a, sb4_q.pop_front());

            @(posedge clk);
            #1;
            mem_valid4 = 1'b1;
            mem_last4  = 1'b1;
            mem_data4  = 32'hD0 + 32'(b);
            ed = '0;
            ed[k*32 +: 32] = 32'hD0 + 32'(b);
            @(negedge clk);
            cmp4($sformatf("n4_rsp%0d", b),
                 {52'h0, rsp_valid4, rsp_last4, rsp_dr4} ^ {32'h0, rsp_data4[k*32 +: 32]},
                 {52'h0, 4'(1 << k), 4'(1 << k), 4'h0} ^ {32'h0, ed[k*32 +: 32]});
            cmp4($sformatf("n4_rsp_other%0d", b), 64'(rsp_data4 ^ ed), 64'h0);

            @(posedge clk);
            #1;
            mem_valid4 = 1'b0;
            mem_last4  = 1'b0;
            mem_data4  = '0;
            req_valid4 = 4'hF & ~4'(1 << k);
            @(posedge clk);
            #1;
            req_valid4 = 4'hF;
        end
        req_valid4 = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
